// File: rtl/regbus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : regbus_ctrl
//  Purpose  : Register-bus initiator for Processor X. Sequences write-back
//             and operand-fetch requests onto the single 8x16 register-file
//             bus. Write-back has priority; fetched operands are returned on
//             a valid/ready handshake and held stable until accepted.
//  Options  : REGBUS_ZERO_REG_EN - register 0 reads as zero, writes to it
//             are accepted but never reach the bus.
//  Revision : 1.0 - initial release
// ============================================================================
module regbus_ctrl #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   // operand-fetch request from decode
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_rs1,
   input  logic [ADDR_W-1:0] req_rs2,
   // operand return
   output logic              op_valid,
   input  logic              op_ready,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   // write-back request from execute
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [ADDR_W-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   // register-file bus
   output logic [ADDR_W-1:0] bus_rs1,
   output logic [ADDR_W-1:0] bus_rs2,
   input  logic [DATA_W-1:0] bus_data_rs1,
   input  logic [DATA_W-1:0] bus_data_rs2,
   output logic [ADDR_W-1:0] bus_rd,
   output logic [DATA_W-1:0] bus_data_in,
   output logic              bus_we
);

`ifdef REGBUS_ZERO_REG_EN
   localparam bit ZERO_REG_EN = 1'b1;
`else
   localparam bit ZERO_REG_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t              state_q,       state_d;
   logic [ADDR_W-1:0]   bus_rs1_q,     bus_rs1_d;
   logic [ADDR_W-1:0]   bus_rs2_q,     bus_rs2_d;
   logic [ADDR_W-1:0]   bus_rd_q,      bus_rd_d;
   logic [DATA_W-1:0]   bus_data_in_q, bus_data_in_d;
   logic [DATA_W-1:0]   op_a_q,        op_a_d;
   logic [DATA_W-1:0]   op_b_q,        op_b_d;

   logic                w_req_ready;
   logic                w_wb_ready;
   logic                w_op_valid;
   logic                w_bus_we;
   logic                w_wb_to_zero;

   // A write-back aimed at the hard-wired zero register is swallowed in IDLE
   assign w_wb_to_zero = ZERO_REG_EN && (wb_rd == '0);

   // Next-state, bus-latch and handshake decode
   always_comb begin
      state_d       = state_q;
      bus_rs1_d     = bus_rs1_q;
      bus_rs2_d     = bus_rs2_q;
      bus_rd_d      = bus_rd_q;
      bus_data_in_d = bus_data_in_q;
      op_a_d        = op_a_q;
      op_b_d        = op_b_q;
      w_req_ready   = 1'b0;
      w_wb_ready    = 1'b0;
      w_op_valid    = 1'b0;
      w_bus_we      = 1'b0;
      unique case (state_q)
         IDLE: begin
            w_wb_ready  = 1'b1;
            w_req_ready = !wb_valid;
            if (wb_valid) begin
               if (!w_wb_to_zero) begin
                  state_d       = WRITE;
                  bus_rd_d      = wb_rd;
                  bus_data_in_d = wb_data;
               end
            end else if (req_valid) begin
               state_d   = READ;
               bus_rs1_d = req_rs1;
               bus_rs2_d = req_rs2;
            end
         end
         WRITE: begin
            w_bus_we = 1'b1;
            state_d  = IDLE;
         end
         READ: begin
            // Register-file read data is combinational from the indices
            // driven this cycle, so it is captured at the end of READ.
            op_a_d  = (ZERO_REG_EN && (bus_rs1_q == '0)) ? '0 : bus_data_rs1;
            op_b_d  = (ZERO_REG_EN && (bus_rs2_q == '0)) ? '0 : bus_data_rs2;
            state_d = HOLD;
         end
         HOLD: begin
            w_op_valid = 1'b1;
            if (op_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and bus/operand registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         bus_rs1_q     <= '0;
         bus_rs2_q     <= '0;
         bus_rd_q      <= '0;
         bus_data_in_q <= '0;
         op_a_q        <= '0;
         op_b_q        <= '0;
      end else begin
         state_q       <= state_d;
         bus_rs1_q     <= bus_rs1_d;
         bus_rs2_q     <= bus_rs2_d;
         bus_rd_q      <= bus_rd_d;
         bus_data_in_q <= bus_data_in_d;
         op_a_q        <= op_a_d;
         op_b_q        <= op_b_d;
      end
   end

   // Handshakes and write enable are forced low while reset is held, so an
   // asserted rst_n kills bus_we immediately and nothing is accepted.
   assign req_ready   = w_req_ready & rst_n;
   assign wb_ready    = w_wb_ready  & rst_n;
   assign op_valid    = w_op_valid  & rst_n;
   assign bus_we      = w_bus_we    & rst_n;

   assign bus_rs1     = bus_rs1_q;
   assign bus_rs2     = bus_rs2_q;
   assign bus_rd      = bus_rd_q;
   assign bus_data_in = bus_data_in_q;
   assign op_a        = op_a_q;
   assign op_b        = op_b_q;

endmodule
`default_nettype wire

// File: tb/tb_regbus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regbus_ctrl
//  Purpose  : Self-checking bench for regbus_ctrl. Provides an 8x16 register
//             file on the bus, directed scenarios with literal expectations,
//             and a randomized phase checked every cycle against an
//             architectural model (pending write, outstanding fetch, regs).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regbus_ctrl;

`ifdef REGBUS_ZERO_REG_EN
   localparam bit ZERO = 1'b1;
`else
   localparam bit ZERO = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  req_rs1 = '0;
   logic [2:0]  req_rs2 = '0;
   logic        op_valid;
   logic        op_ready = 1'b0;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic        wb_valid = 1'b0;
   logic        wb_ready;
   logic [2:0]  wb_rd = '0;
   logic [15:0] wb_data = '0;
   logic [2:0]  bus_rs1;
   logic [2:0]  bus_rs2;
   logic [15:0] bus_data_rs1;
   logic [15:0] bus_data_rs2;
   logic [2:0]  bus_rd;
   logic [15:0] bus_data_in;
   logic        bus_we;

   int n_checks = 0;
   int n_err    = 0;

   regbus_ctrl #(.DATA_W(16), .ADDR_W(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_rs1(req_rs1), .req_rs2(req_rs2),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_a(op_a), .op_b(op_b),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_rd(wb_rd), .wb_data(wb_data),
      .bus_rs1(bus_rs1), .bus_rs2(bus_rs2),
      .bus_data_rs1(bus_data_rs1), .bus_data_rs2(bus_data_rs2),
      .bus_rd(bus_rd), .bus_data_in(bus_data_in), .bus_we(bus_we)
   );

   always #5 clk = ~clk;

   // Register file on the far side of the bus
   logic [15:0] rf [8] = '{default: 16'h0};
   assign bus_data_rs1 = rf[bus_rs1];
   assign bus_data_rs2 = rf[bus_rs2];
   always @(posedge clk) if (bus_we) rf[bus_rd] <= bus_data_in;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- architectural model + per-cycle compare ----------------
   logic [15:0] mreg [8] = '{default: 16'h0};
   bit          pend_wr = 0;       // a write is on the bus this cycle
   bit          rd_out  = 0;       // a fetch has been accepted, not yet consumed
   int          rd_age  = 0;       // cycles since fetch handshake
   logic [2:0]  e_rd = '0, e_rs1 = '0, e_rs2 = '0;
   logic [15:0] e_din = '0, e_a = '0, e_b = '0, n_a = '0, n_b = '0;

   always @(negedge clk) begin
      bit e_wbr, e_rqr, e_opv;
      if (!rst_n) begin
         chk("rst_wb_ready", wb_ready, 0);
         chk("rst_req_ready", req_ready, 0);
         chk("rst_op_valid", op_valid, 0);
         chk("rst_bus_we", bus_we, 0);
         chk("rst_op_a", op_a, 0);
         chk("rst_op_b", op_b, 0);
         chk("rst_bus_rs", {bus_rs1, bus_rs2, bus_rd}, 0);
         chk("rst_bus_din", bus_data_in, 0);
         pend_wr = 0; rd_out = 0; rd_age = 0;
         e_rd = '0; e_rs1 = '0; e_rs2 = '0; e_din = '0; e_a = '0; e_b = '0;
      end else begin
         e_wbr = !(pend_wr || rd_out);
         e_rqr = e_wbr && !wb_valid;
         e_opv = rd_out && (rd_age >= 2);
         chk("wb_ready", wb_ready, e_wbr);
         chk("req_ready", req_ready, e_rqr);
         chk("op_valid", op_valid, e_opv);
         chk("bus_we", bus_we, pend_wr);
         chk("bus_rd", bus_rd, e_rd);
         chk("bus_data_in", bus_data_in, e_din);
         chk("bus_rs1", bus_rs1, e_rs1);
         chk("bus_rs2", bus_rs2, e_rs2);
         chk("op_a", op_a, e_a);
         chk("op_b", op_b, e_b);
         // advance the model to the next cycle
         if (pend_wr) begin
            mreg[e_rd] = e_din;
            pend_wr = 0;
         end
         if (rd_out) begin
            if (rd_age == 1) begin
               e_a = n_a; e_b = n_b; rd_age = 2;
            end else if (op_ready) begin
               rd_out = 0;
            end
         end
         if (e_wbr && wb_valid) begin
            if (!(ZERO && wb_rd == 3'd0)) begin
               pend_wr = 1; e_rd = wb_rd; e_din = wb_data;
            end
         end else if (e_rqr && req_valid) begin
            rd_out = 1; rd_age = 1; e_rs1 = req_rs1; e_rs2 = req_rs2;
            n_a = (ZERO && req_rs1 == 3'd0) ? 16'h0 : mreg[req_rs1];
            n_b = (ZERO && req_rs2 == 3'd0) ? 16'h0 : mreg[req_rs2];
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_write(input logic [2:0] rd, input logic [15:0] d);
      bit hs = 0;
      wb_valid = 1; wb_rd = rd; wb_data = d;
      for (int k = 0; k < 50 && !hs; k++) begin
         @(negedge clk); hs = wb_ready;
         @(posedge clk); #1;
      end
      wb_valid = 0;
      if (!hs) chk("wr_timeout", 0, 1);
   endtask

   task automatic do_read(input logic [2:0] rs1, input logic [2:0] rs2,
                          output logic [15:0] a, output logic [15:0] b);
      bit hs = 0;
      bit got = 0;
      int lat = 0;
      a = '0; b = '0;
      req_valid = 1; req_rs1 = rs1; req_rs2 = rs2; op_ready = 1;
      for (int k = 0; k < 50 && !hs; k++) begin
         @(negedge clk); hs = req_ready;
         @(posedge clk); #1;
      end
      req_valid = 0;
      if (!hs) chk("rd_timeout", 0, 1);
      for (int k = 1; k <= 20 && !got; k++) begin
         @(negedge clk);
         if (op_valid) begin got = 1; lat = k; a = op_a; b = op_b; end
      end
      @(posedge clk); #1;
      op_ready = 0;
      chk("rd_latency", lat, 2);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [15:0] a, b;
      bit hs;
      int nh, nv;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;

      // write r3 then fetch it on both ports
      do_write(3'd3, 16'hBEEF);
      chk("w1_bus_we", bus_we, 1);
      chk("w1_bus_rd", bus_rd, 3);
      @(posedge clk); #1;
      chk("w1_we_one_cycle", bus_we, 0);
      do_read(3'd3, 3'd3, a, b);
      chk("r1_op_a", a, 16'hBEEF);
      chk("r1_op_b", b, 16'hBEEF);

      // simultaneous write-back and fetch: write wins, fetch sees it
      wb_valid = 1; wb_rd = 3'd5; wb_data = 16'h1234;
      req_valid = 1; req_rs1 = 3'd5; req_rs2 = 3'd0;
      @(negedge clk);
      chk("sim_req_ready", req_ready, 0);
      chk("sim_wb_ready", wb_ready, 1);
      @(posedge clk); #1;
      wb_valid = 0;
      chk("sim_bus_we", bus_we, 1);
      do_read(3'd5, 3'd0, a, b);
      chk("sim_op_a", a, 16'h1234);
      chk("sim_op_b", b, 16'h0000);

      // stall in HOLD with a write-back waiting
      req_valid = 1; req_rs1 = 3'd3; req_rs2 = 3'd5; op_ready = 0;
      hs = 0;
      for (int k = 0; k < 50 && !hs; k++) begin
         @(negedge clk); hs = req_ready;
         @(posedge clk); #1;
      end
      req_valid = 0;
      hs = 0;
      for (int k = 0; k < 10 && !hs; k++) begin
         @(negedge clk); hs = op_valid;
      end
      chk("hold_reached", hs, 1);
      @(posedge clk); #1;
      wb_valid = 1; wb_rd = 3'd6; wb_data = 16'hA5A5;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("hold_wb_ready", wb_ready, 0);
         chk("hold_bus_we", bus_we, 0);
         chk("hold_op_a", op_a, 16'hBEEF);
         chk("hold_op_b", op_b, 16'h1234);
         @(posedge clk); #1;
      end
      op_ready = 1;
      @(posedge clk); #1;
      op_ready = 0;
      @(negedge clk);
      chk("post_hold_wb_ready", wb_ready, 1);
      @(posedge clk); #1;
      wb_valid = 0;
      chk("post_hold_we", bus_we, 1);
      chk("post_hold_rd", bus_rd, 6);

      // register 0 behaviour
      do_write(3'd0, 16'hFFFF);
      chk("r0_bus_we", bus_we, ZERO ? 0 : 1);
      do_read(3'd0, 3'd6, a, b);
      chk("r0_op_a", a, ZERO ? 16'h0000 : 16'hFFFF);
      chk("r0_op_b", b, 16'hA5A5);

      // reset in the middle of a write drops it
      do_write(3'd3, 16'h5555);
      chk("rw_we_before", bus_we, 1);
      rst_n = 0;
      #1;
      chk("rw_we_async", bus_we, 0);
      chk("rw_wb_ready", wb_ready, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      do_read(3'd3, 3'd3, a, b);
      chk("rw_r3_kept", a, 16'hBEEF);

      // back-to-back fetches with consumer always ready
      req_valid = 1; req_rs1 = 3'd5; req_rs2 = 3'd6; op_ready = 1;
      nh = 0; nv = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (req_ready) nh++;
         if (op_valid) nv++;
      end
      @(posedge clk); #1;
      req_valid = 0; op_ready = 0;
      chk("b2b_accepts", nh, 4);
      chk("b2b_op_valids", nv, 4);
      repeat (4) @(posedge clk);
      #1;

      // randomized traffic with occasional asynchronous resets
      for (int i = 0; i < 1500; i++) begin
         if (!rst_n) rst_n = 1;
         else if ($urandom_range(0, 99) == 0) rst_n = 0;
         wb_valid  = ($urandom_range(0, 3) == 0);
         wb_rd     = 3'($urandom_range(0, 7));
         wb_data   = 16'($urandom);
         req_valid = ($urandom_range(0, 1) == 0);
         req_rs1   = 3'($urandom_range(0, 7));
         req_rs2   = 3'($urandom_range(0, 7));
         op_ready  = ($urandom_range(0, 2) != 0);
         @(posedge clk); #1;
      end
      rst_n = 1; wb_valid = 0; req_valid = 0; op_ready = 1;
      repeat (5) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
